// File: rtl/clk_rst_pkg.sv
// +------------------------------------------------------------------+
// | clk_rst_pkg : state encodings shared by the MMCM reset sequencer  |
// | rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

package clk_rst_pkg;
  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_MMCM_RST  = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_HOLD      = 3'd2,
    S_RUN       = 3'd3,
    S_FAIL      = 3'd4
  } seq_state_e;
endpackage

`default_nettype wire

// File: rtl/clk_rst_seq_bit_sync.sv
// +------------------------------------------------------------------+
// | bit_sync : STAGES-flop async-reset synchronizer, resets to 0      |
// | rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb sync_d = {sync_q[STAGES-2:0], d};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= sync_d;
  end

  assign q = sync_q[STAGES-1];
endmodule

`default_nettype wire

// File: rtl/clk_rst_seq.sv
// +------------------------------------------------------------------+
// | clk_rst_seq : MMCM reset/lock sequencer producing a clean user    |
// | reset. Optional lock-loss counter: CLK_RST_SEQ_STATS_EN. rev 1.0  |
// +------------------------------------------------------------------+
`default_nettype none

module clk_rst_seq
  import clk_rst_pkg::*;
#(
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_TIMEOUT = 1000000,
  parameter int HOLD_CYCLES  = 1024,
  parameter int MAX_RETRY    = 3,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                           sys_clk,
  input  logic                           rst_n,
  input  logic                           locked_i,
  input  logic                           force_relock,
  output logic                           mmcm_resetn,
  output logic                           rst_out_n,
  output logic [STATE_W-1:0]             seq_state,
  output logic [$clog2(MAX_RETRY+1)-1:0] retry_cnt,
`ifdef CLK_RST_SEQ_STATS_EN
  output logic [15:0]                    lock_loss_cnt,
`endif
  output logic                           fail
);
  localparam int CNT_MAX0 = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int CNT_MAX  = (CNT_MAX0 > HOLD_CYCLES) ? CNT_MAX0 : HOLD_CYCLES;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);
  localparam int RTY_W    = $clog2(MAX_RETRY + 1);

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RTY_W-1:0] retry_q, retry_d, retry_inc;
  logic             fail_q, fail_d;
  logic             mmcm_resetn_q, mmcm_resetn_d;
  logic             rst_out_n_q, rst_out_n_d;
  logic             lk_s;
  logic             timeout;

  bit_sync #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .clk   (sys_clk),
    .rst_n (rst_n),
    .d     (locked_i),
    .q     (lk_s)
  );

  assign retry_inc = retry_q + RTY_W'(1);
  assign timeout   = (cnt_q == CNT_W'(LOCK_TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_MMCM_RST:  if (cnt_q == CNT_W'(RST_CYCLES - 1)) state_d = S_WAIT_LOCK;
      S_WAIT_LOCK: begin
        if (lk_s)         state_d = S_HOLD;
        else if (timeout) state_d = (retry_inc == RTY_W'(MAX_RETRY)) ? S_FAIL : S_MMCM_RST;
      end
      S_HOLD: begin
        if (!lk_s)                                  state_d = S_WAIT_LOCK;
        else if (cnt_q == CNT_W'(HOLD_CYCLES - 1))  state_d = S_RUN;
      end
      S_RUN:   if (!lk_s) state_d = S_MMCM_RST;
      S_FAIL:  state_d = S_FAIL;
      default: state_d = S_MMCM_RST;
    endcase
    if (force_relock) state_d = S_MMCM_RST;
  end

  always_comb begin
    retry_d = retry_q;
    if (state_q == S_WAIT_LOCK && !lk_s && timeout) retry_d = retry_inc;
    if (state_d == S_RUN || force_relock)           retry_d = '0;

    fail_d = fail_q;
    if (state_d == S_FAIL) fail_d = 1'b1;
    if (force_relock)      fail_d = 1'b0;

    // RUN and FAIL can persist indefinitely, so the counter idles at 0 there
    if (force_relock || state_d != state_q || state_q == S_RUN || state_q == S_FAIL)
      cnt_d = '0;
    else
      cnt_d = cnt_q + CNT_W'(1);

    mmcm_resetn_d = (state_d == S_WAIT_LOCK) || (state_d == S_HOLD) || (state_d == S_RUN);
    rst_out_n_d   = (state_d == S_RUN);
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_MMCM_RST;
      cnt_q         <= '0;
      retry_q       <= '0;
      fail_q        <= 1'b0;
      mmcm_resetn_q <= 1'b0;
      rst_out_n_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      retry_q       <= retry_d;
      fail_q        <= fail_d;
      mmcm_resetn_q <= mmcm_resetn_d;
      rst_out_n_q   <= rst_out_n_d;
    end
  end

`ifdef CLK_RST_SEQ_STATS_EN
  logic [15:0] loss_q, loss_d;

  always_comb begin
    loss_d = loss_q;
    if (state_q == S_RUN && !lk_s && !force_relock && loss_q != 16'hFFFF)
      loss_d = loss_q + 16'd1;
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) loss_q <= '0;
    else        loss_q <= loss_d;
  end

  assign lock_loss_cnt = loss_q;
`endif

  assign mmcm_resetn = mmcm_resetn_q;
  assign rst_out_n   = rst_out_n_q;
  assign seq_state   = state_q;
  assign retry_cnt   = retry_q;
  assign fail        = fail_q;
endmodule

`default_nettype wire

// File: tb/tb_clk_rst_seq.sv
// +------------------------------------------------------------------+
// | tb_clk_rst_seq : scoreboard bench for the MMCM reset sequencer    |
// | rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module tb_clk_rst_seq;
  logic       sys_clk = 1'b0;
  logic       rst_n, locked_i, force_relock;
  logic       mmcm_resetn, rst_out_n, fail;
  logic [2:0] seq_state;
  logic [1:0] retry_cnt;
`ifdef CLK_RST_SEQ_STATS_EN
  logic [15:0] lock_loss_cnt;
`endif

  int n_total = 0;
  int n_bad   = 0;
  string exp_tag_q[$];
  int    exp_val_q[$];

  clk_rst_seq #(
    .RST_CYCLES(4), .LOCK_TIMEOUT(100), .HOLD_CYCLES(8), .MAX_RETRY(2), .SYNC_STAGES(2)
  ) dut (
    .sys_clk      (sys_clk),
    .rst_n        (rst_n),
    .locked_i     (locked_i),
    .force_relock (force_relock),
    .mmcm_resetn  (mmcm_resetn),
    .rst_out_n    (rst_out_n),
    .seq_state    (seq_state),
    .retry_cnt    (retry_cnt),
`ifdef CLK_RST_SEQ_STATS_EN
    .lock_loss_cnt(lock_loss_cnt),
`endif
    .fail         (fail)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic expect_val(input string tag, input int val);
    exp_tag_q.push_back(tag);
    exp_val_q.push_back(val);
  endtask

  task automatic sb_check(input int obs);
    if (exp_tag_q.size() == 0) begin
      check("sb_empty", 1, 0);
    end else begin
      string t;
      int    v;
      t = exp_tag_q.pop_front();
      v = exp_val_q.pop_front();
      check(t, obs, v);
    end
  endtask

  task automatic check_outs(input string tag, input int st, input int mr, input int ro,
                            input int rc, input int fl);
    expect_val({tag, ".state"}, st);
    expect_val({tag, ".mmcm_resetn"}, mr);
    expect_val({tag, ".rst_out_n"}, ro);
    expect_val({tag, ".retry_cnt"}, rc);
    expect_val({tag, ".fail"}, fl);
    sb_check(int'(seq_state));
    sb_check(int'(mmcm_resetn));
    sb_check(int'(rst_out_n));
    sb_check(int'(retry_cnt));
    sb_check(int'(fail));
  endtask

  task automatic check_state(input string tag, input int st);
    expect_val(tag, st);
    sb_check(int'(seq_state));
  endtask

  task automatic check_loss(input string tag, input int val);
`ifdef CLK_RST_SEQ_STATS_EN
    expect_val(tag, val);
    sb_check(int'(lock_loss_cnt));
`endif
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic wait_state(input string tag, input int target, input int limit);
    for (int i = 0; i < limit && int'(seq_state) != target; i++) tick();
    check(tag, int'(seq_state), target);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; locked_i = 1'b0; force_relock = 1'b0;
    ticks(3);
    check_outs("reset", 0, 0, 0, 0, 0);
    check_loss("reset.loss", 0);

    // normal bring-up
    rst_n = 1'b1;
    ticks(3);
    check_outs("mmcm_rst", 0, 0, 0, 0, 0);
    tick();
    check_outs("wait_lock", 1, 1, 0, 0, 0);
    ticks(6);
    locked_i = 1'b1;
    ticks(10);
    check_outs("hold_end", 2, 1, 0, 0, 0);
    tick();
    check_outs("normal_run", 3, 1, 1, 0, 0);

    // lock loss in RUN
    locked_i = 1'b0;
    ticks(2);
    check_outs("loss_pre", 3, 1, 1, 0, 0);
    tick();
    check_outs("loss", 0, 0, 0, 0, 0);
    check_loss("loss.cnt", 1);
    ticks(3);
    check_outs("loss_rst", 0, 0, 0, 0, 0);
    tick();
    check_outs("loss_wait", 1, 1, 0, 0, 0);
    locked_i = 1'b1;
    ticks(11);
    check_outs("relock_run", 3, 1, 1, 0, 0);

    // force_relock coincides with synced lock fall
    locked_i = 1'b0;
    ticks(2);
    check_state("force_pre", 3);
    force_relock = 1'b1;
    tick();
    force_relock = 1'b0;
    check_outs("force_loss", 0, 0, 0, 0, 0);
    check_loss("force_loss.cnt", 1);

    // short lock glitch while holding
    wait_state("glitch_wait", 1, 10);
    locked_i = 1'b1;
    ticks(4);
    check_state("glitch_hold", 2);
    tick();
    locked_i = 1'b0;
    ticks(2);
    check_state("glitch_hold2", 2);
    tick();
    check_outs("glitch_back", 1, 1, 0, 0, 0);
    locked_i = 1'b1;
    ticks(11);
    check_outs("glitch_run", 3, 1, 1, 0, 0);

    // lock timeouts leading to FAIL
    locked_i = 1'b0;
    ticks(3);
    check_state("tmo_loss", 0);
    check_loss("tmo_loss.cnt", 2);
    ticks(3);
    tick();
    check_outs("tmo_wait", 1, 1, 0, 0, 0);
    ticks(99);
    check_state("tmo_wait_end", 1);
    tick();
    check_outs("tmo1", 0, 0, 0, 1, 0);
    ticks(4);
    check_outs("tmo1_wait", 1, 1, 0, 1, 0);
    ticks(99);
    check_outs("tmo2_pre", 1, 1, 0, 1, 0);
    tick();
    check_outs("fail", 4, 0, 0, 2, 1);
    ticks(5);
    check_outs("fail_sticky", 4, 0, 0, 2, 1);
    force_relock = 1'b1;
    tick();
    force_relock = 1'b0;
    check_outs("fail_relock", 0, 0, 0, 0, 0);

    // async reset in HOLD
    locked_i = 1'b1;
    wait_state("rst_hold", 2, 20);
    #2;
    rst_n = 1'b0;
    #1;
    check_outs("async_rst", 0, 0, 0, 0, 0);
    check_loss("async_rst.loss", 0);
    ticks(2);
    check_outs("async_rst_held", 0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

`default_nettype wire
